// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing and parity helper.
package ps2_pkg;

  localparam int DEF_CLK_HZ     = 25_000_000;
  localparam int DEF_INHIBIT_US = 100;
  localparam int DEF_TIMEOUT_US = 15_000;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERR
  } state_t;

  // Odd parity: data plus parity bit always carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// PS/2 line conditioner: 2-FF synchronizer, 8-sample stability filter and a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync_reg;
  logic [7:0] win_reg;
  logic       level_reg;
  logic       fall_reg;

  // Idle PS/2 lines float high, so everything resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '1;
      win_reg   <= '1;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pin};
      win_reg  <= {win_reg[6:0], sync_reg[1]};
      fall_reg <= 1'b0;
      if (&win_reg) begin
        level_reg <= 1'b1;
      end else if (~|win_reg) begin
        level_reg <= 1'b0;
        fall_reg  <= level_reg;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a command byte out on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int INHIBIT_US = DEF_INHIBIT_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       done,
  output logic       err,
  output logic       tx_active,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int CW      = $clog2(TO_CYC + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [9:0]    shreg_reg, shreg_next;
  logic [3:0]    bitcnt_reg, bitcnt_next;
  logic          drive_reg, drive_next;
  logic          c_level, c_fall, d_level, d_fall_unused;
  logic          timed_out, inhibit_end;

  ps2_sync u_sync_c (
    .clk  (clk),
    .rst  (rst),
    .pin  (ps2c_i),
    .level(c_level),
    .fall (c_fall)
  );

  ps2_sync u_sync_d (
    .clk  (clk),
    .rst  (rst),
    .pin  (ps2d_i),
    .level(d_level),
    .fall (d_fall_unused)
  );

  assign inhibit_end = (cnt_reg == CW'(INH_CYC - 1));
  assign timed_out   = (cnt_reg == CW'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      drive_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shreg_reg  <= shreg_next;
      bitcnt_reg <= bitcnt_next;
      drive_reg  <= drive_next;
    end
  end

  // One counter serves both the inhibit hold and the ACK timeout.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    drive_next  = drive_reg;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          shreg_next = {1'b1, odd_parity(data), data};
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inhibit_end) begin
          cnt_next   = '0;
          state_next = RTS;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RTS: begin
        // Counter starts at 1 so its value equals cycles elapsed since RTS.
        cnt_next    = CW'(1);
        bitcnt_next = '0;
        drive_next  = 1'b1;
        state_next  = SHIFT;
      end
      SHIFT: begin
        cnt_next = cnt_reg + 1'b1;
        if (timed_out) begin
          state_next = ERR;
        end else if (c_fall) begin
          drive_next  = ~shreg_reg[0];
          shreg_next  = {1'b1, shreg_reg[9:1]};
          bitcnt_next = bitcnt_reg + 4'd1;
          if (bitcnt_reg == 4'd9) state_next = ACK;
        end
      end
      ACK: begin
        cnt_next = cnt_reg + 1'b1;
        if (timed_out) state_next = ERR;
        else if (c_fall) state_next = d_level ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_next = cnt_reg + 1'b1;
        if (c_level && d_level) state_next = IDLE;
        else if (timed_out) state_next = ERR;
      end
      ERR: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdy       = (state_reg == IDLE);
    tx_active = ~rdy;
    ps2c_oe   = (state_reg == INHIBIT);
    ps2d_oe   = (state_reg == RTS) || ((state_reg == SHIFT) && drive_reg);
    done      = (state_reg == WAIT_IDLE) && c_level && d_level;
    err       = (state_reg == ERR);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain bus with a PS/2 device model
// that clocks frames, records the bits it sees and optionally ACKs.
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 2_000_000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 5000;
  localparam int INH_CYC    = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC     = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int HP         = 80;  // half period of a 12.5 kHz device clock

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy, done, err, tx_active, ps2c_oe, ps2d_oe;
  logic       ps2c_i, ps2d_i;
  logic       dev_c_low = 1'b0, dev_d_low = 1'b0, glitch = 1'b0;

  int errors = 0, checks = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rdy_bad = 0;
  int rts_cyc = 0, err_cyc = 0;
  logic prev_c_oe = 1'b0;

  assign ps2c_i = ~(ps2c_oe | dev_c_low) ^ glitch;
  assign ps2d_i = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(
    .CLK_HZ    (CLK_HZ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .rdy      (rdy),
    .done     (done),
    .err      (err),
    .tx_active(tx_active),
    .ps2c_i   (ps2c_i),
    .ps2d_i   (ps2d_i),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done === 1'b1 && err === 1'b1) both_cnt++;
    if (rdy !== ~tx_active) rdy_bad++;
    if (prev_c_oe === 1'b1 && ps2c_oe === 1'b0 && ps2d_oe === 1'b1) rts_cyc = cyc;
    prev_c_oe = ps2c_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bits a device sees on its rising clock edges: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic begin_tx(input logic [7:0] b);
    int n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      wait_cyc(1);
      n++;
    end
    chk("rdy_before_start", rdy, 1);
    start = 1'b1;
    data  = b;
    wait_cyc(1);
    start = 1'b0;
    data  = 8'($urandom);
    chk("start_latency_c_oe", ps2c_oe, 1);
    n = 0;
    while (ps2c_oe === 1'b1 && n < INH_CYC + 10) begin
      wait_cyc(1);
      n++;
    end
    chk("inhibit_len", n, INH_CYC);
    chk("rts_d_oe", ps2d_oe, 1);
  endtask

  task automatic half_phase(input bit glitchy);
    if (glitchy) begin
      wait_cyc(HP / 2);
      glitch = 1'b1;
      wait_cyc(1);
      glitch = 1'b0;
      wait_cyc(HP / 2 - 1);
    end else begin
      wait_cyc(HP);
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit ack, input bit glitchy,
                       input bit inject, input int rst_after);
    logic [10:0] got;
    int          d0, e0, n;
    bit          aborted;
    got     = '1;
    aborted = 1'b0;
    d0      = done_cnt;
    e0      = err_cnt;
    begin_tx(b);
    got[0] = ps2d_i;
    for (int k = 1; k <= 10; k++) begin
      if (!aborted) begin
        if (inject && k == 5) begin
          wait_cyc(HP / 2);
          chk("busy_rdy", rdy, 0);
          start = 1'b1;
          data  = 8'h00;
          wait_cyc(1);
          start = 1'b0;
          wait_cyc(HP / 2 - 1);
        end else begin
          half_phase(glitchy);
        end
        dev_c_low = 1'b1;
        half_phase(glitchy);
        dev_c_low = 1'b0;
        got[k] = ps2d_i;
        if (rst_after == k) begin
          wait_cyc(5);
          rst = 1'b1;
          wait_cyc(1);
          rst = 1'b0;
          chk("rst_oe", {ps2c_oe, ps2d_oe}, 0);
          chk("rst_rdy", rdy, 1);
          chk("rst_done_err", {done, err}, 0);
          wait_cyc(3);
          chk("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
          aborted = 1'b1;
        end
      end
    end
    if (!aborted) begin
      wait_cyc(HP / 2);
      dev_d_low = ack;
      wait_cyc(HP / 2);
      dev_c_low = 1'b1;
      wait_cyc(HP);
      dev_c_low = 1'b0;
      wait_cyc(HP / 2);
      dev_d_low = 1'b0;
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
        wait_cyc(1);
        n++;
      end
      chk("tx_active_after_end", tx_active, 0);
      wait_cyc(5);
      $display("frame data=%02h ack=%0d bits=%03h done=%0d err=%0d", b, ack, got,
               done_cnt - d0, err_cnt - e0);
      chk("frame_bits", got, model_frame(b));
      chk("done_count", done_cnt - d0, ack ? 1 : 0);
      chk("err_count", err_cnt - e0, ack ? 0 : 1);
      chk("oe_released", {ps2c_oe, ps2d_oe}, 0);
    end
  endtask

  task automatic timeout_case(input logic [7:0] b);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    begin_tx(b);
    n = 0;
    while (err_cnt == e0 && n < TO_CYC + 100) begin
      wait_cyc(1);
      n++;
    end
    $display("timeout data=%02h rts=%0d err=%0d", b, rts_cyc, err_cyc);
    chk("timeout_err_seen", err_cnt - e0, 1);
    chk("timeout_latency", err_cyc - rts_cyc, TO_CYC);
    chk("timeout_release", {ps2c_oe, ps2d_oe}, 0);
    chk("timeout_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    wait_cyc(3);
    chk("reset_rdy", rdy, 1);
    chk("reset_tx_active", tx_active, 0);
    chk("reset_done_err", {done, err}, 0);
    chk("reset_oe", {ps2c_oe, ps2d_oe}, 0);
    rst = 1'b0;
    wait_cyc(20);

    frame(8'hED, 1'b1, 1'b0, 1'b0, 0);
    frame(8'hF4, 1'b1, 1'b0, 1'b0, 0);
    frame(8'($urandom), 1'b0, 1'b0, 1'b0, 0);
    timeout_case(8'($urandom));
    wait_cyc(20);
    frame(8'hED, 1'b1, 1'b0, 1'b1, 0);
    frame(8'hED, 1'b1, 1'b0, 1'b0, 4);
    wait_cyc(20);
    frame(8'hFF, 1'b1, 1'b0, 1'b0, 0);
    frame(8'($urandom), 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) frame(8'($urandom), 1'b1, 1'b0, 1'b0, 0);

    chk("done_err_overlap", both_cnt, 0);
    chk("rdy_vs_tx_active", rdy_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
